// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line conditioning.
// Holds the state encoding, default timing parameters and the filter depth.
package ps2_pkg;

    localparam int unsigned INHIBIT_CYCLES_DEF = 5000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;
    localparam int unsigned FILT_LEN           = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INHIBIT   = 4'd1,
        ST_RTS       = 4'd2,
        ST_DATA      = 4'd3,
        ST_PARITY    = 4'd4,
        ST_STOP      = 4'd5,
        ST_ACK       = 4'd6,
        ST_WAIT_IDLE = 4'd7
    } ps2_tx_state_e;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
interface ps2_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (output tx_data, output tx_start,
                    input  tx_busy, input  tx_done, input tx_err);
    modport slave  (input  tx_data, input  tx_start,
                    output tx_busy, output tx_done, output tx_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus FILT_LEN-sample stability filter for one PS/2 line.
// level_o only changes once the line has been steady for the whole window.
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0]          sync_q, sync_d;
    logic [FILT_LEN-1:0] hist_q, hist_d;
    logic                level_q, level_d;
    logic                fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[0], line_i};
        hist_d  = {hist_q[FILT_LEN-2:0], sync_q[1]};
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
        fall_d = level_q & ~level_d;
    end

    // Idle bus level is high, so everything presets to 1 to avoid a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            hist_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked-out
// data/parity/stop under device clock, ACK check and inter-edge timeout.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2c,
    input  logic        ps2d,
    output logic        ps2c_oe,
    output logic        ps2d_oe,
    ps2_tx_if.slave     bus,
    output logic [31:0] debug_out
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_e state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic          ack_ok_q, ack_ok_d;
    logic          c_oe_q, c_oe_d;
    logic          d_oe_q, d_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [7:0]    done_cnt_q, done_cnt_d;

    logic c_level, c_fall;
    logic d_level, d_fall_unused;

    ps2_line_filter u_clk_filt (
        .clk     (clk),
        .rst_n   (rst),
        .line_i  (ps2c),
        .level_o (c_level),
        .fall_o  (c_fall)
    );

    ps2_line_filter u_dat_filt (
        .clk     (clk),
        .rst_n   (rst),
        .line_i  (ps2d),
        .level_o (d_level),
        .fall_o  (d_fall_unused)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_d      = par_q;
        inh_cnt_d  = inh_cnt_q;
        tmo_d      = tmo_q;
        ack_ok_d   = ack_ok_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    data_d    = bus.tx_data;
                    par_d     = odd_parity(bus.tx_data);
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES)) begin
                    tmo_d   = '0;
                    state_d = ST_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_RTS: begin
                if (c_fall) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (c_fall) begin
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: if (c_fall) state_d = ST_STOP;
            ST_STOP:   if (c_fall) state_d = ST_ACK;
            ST_ACK: begin
                if (c_fall) begin
                    ack_ok_d = ~d_level;
                    state_d  = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (c_level && d_level) begin
                    done_d  = ack_ok_q;
                    err_d   = ~ack_ok_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout overrides any normal completion in the same cycle so done/err stay exclusive.
        if (state_q inside {ST_RTS, ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE}) begin
            if (c_fall) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                done_d  = 1'b0;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        err_cnt_d  = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        done_cnt_d = done_cnt_q;
        if (done_d) begin
            done_cnt_d = done_cnt_q + 8'd1;
        end

        // Line drivers are registered from the next state so the bus never sees decode glitches.
        c_oe_d = (state_d == ST_INHIBIT);
        case (state_d)
            ST_INHIBIT: d_oe_d = (inh_cnt_d == INH_W'(INHIBIT_CYCLES));
            ST_RTS:     d_oe_d = 1'b1;
            ST_DATA:    d_oe_d = ~data_d[bit_cnt_d[2:0]];
            ST_PARITY:  d_oe_d = ~par_d;
            default:    d_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            inh_cnt_q  <= '0;
            tmo_q      <= '0;
            ack_ok_q   <= 1'b0;
            c_oe_q     <= 1'b0;
            d_oe_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            inh_cnt_q  <= inh_cnt_d;
            tmo_q      <= tmo_d;
            ack_ok_q   <= ack_ok_d;
            c_oe_q     <= c_oe_d;
            d_oe_q     <= d_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign ps2c_oe     = c_oe_q;
    assign ps2d_oe     = d_oe_q;
    assign bus.tx_busy = (state_q != ST_IDLE);
    assign bus.tx_done = done_q;
    assign bus.tx_err  = err_q;
    assign debug_out   = {state_q, bit_cnt_q, data_q, err_cnt_q, done_cnt_q};

endmodule
